feedback_seq_ctrl: RTL
======================

FEEDBACK_SEQ_CTRL -- requirements
Module: feedback_seq_ctrl

Interface
REQ-001 Parameter SEL_N, default 10: number of gray-clock taps / selector legs controlled.
REQ-002 Parameter WIN_W, default 8: width of the sample-window and ones counters.
REQ-003 Parameter SETTLE_CYC, default 16: clk_ext cycles waited after selector clear before sampling.
REQ-004 Parameter LOCK_N, default 4: consecutive balanced decisions required to assert lock.
REQ-005 clk_ext  in  1  single core clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level; sampled only in IDLE; begins a calibration run.
REQ-008 stop  in  1  level; aborts any run and returns to IDLE.
REQ-009 phase_sel  in  4  index of the gray-clock tap to enable, valid range 0..SEL_N-1.
REQ-010 win_len  in  WIN_W  sample-window length in cycles; 0 is treated as 1.
REQ-011 threshold  in  WIN_W  target ones count per window.
REQ-012 fb_in  in  1  latched muxed output of the gray selector.
REQ-013 tap_en  out  SEL_N  one-hot gate mask for the gray clocks feeding the selector flops.
REQ-014 sel_clr  out  1  high while selector edge flops are held cleared.
REQ-015 ctr_en  out  1  single-cycle enable pulse to the up/down binary counter.
REQ-016 ctr_ud  out  1  counter direction: 1 = up, 0 = down.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 lock  out  1  loop balanced for LOCK_N consecutive windows.
REQ-019 err  out  1  one-cycle pulse on start with out-of-range phase_sel.
REQ-020 state  out  3  current FSM state encoding, for debug.

Function
REQ-021 FSM states SHALL be IDLE=0, CLEAR=1, SETTLE=2, SAMPLE=3, DECIDE=4, STEP=5.
REQ-022 IDLE: start=1 with phase_sel<SEL_N latches phase_sel, win_len (0 -> 1) and threshold, and moves to CLEAR; start with phase_sel>=SEL_N stays in IDLE and pulses err.
REQ-023 CLEAR SHALL last exactly 2 cycles with sel_clr=1 and tap_en=0, then move to SETTLE.
REQ-024 SETTLE SHALL last exactly SETTLE_CYC cycles with tap_en one-hot at the latched index, then move to SAMPLE.
REQ-025 SAMPLE SHALL last exactly the latched win_len cycles, adding fb_in to a ones counter each cycle; the ones counter clears on SAMPLE entry.
REQ-026 DECIDE (1 cycle): ones>threshold -> ctr_ud=0 and go to STEP; ones<threshold -> ctr_ud=1 and go to STEP; ones==threshold -> increment balance count and return to SAMPLE with no step.
REQ-027 STEP SHALL assert ctr_en for exactly one cycle, clear the balance count, and return to SAMPLE.
REQ-028 ctr_ud SHALL be registered, change only in DECIDE, and hold its value otherwise, including in IDLE.
REQ-029 lock SHALL assert on the cycle the balance count reaches LOCK_N; it stays high while balanced and clears in the cycle after any STEP or on IDLE entry.
REQ-030 The balance count SHALL saturate at LOCK_N.
REQ-031 tap_en SHALL be one-hot in SETTLE/SAMPLE/DECIDE/STEP and zero in IDLE/CLEAR.
REQ-032 stop=1 in any non-IDLE state forces IDLE on the next edge; it suppresses a pending ctr_en, and stop has priority over every transition.
REQ-033 start held high after a run ends does not retrigger until it is seen low for at least one cycle in IDLE.
REQ-034 Changes to phase_sel, win_len or threshold during a run SHALL have no effect until the next start.

Reset
REQ-035 With reset=1 at a clock edge, the block SHALL enter IDLE with tap_en=0, sel_clr=0, ctr_en=0, ctr_ud=1, busy=0, lock=0, err=0, state=0, and all counters cleared.
REQ-036 reset SHALL take priority over stop and start, mid-run included.

Verification
REQ-037 Reset, then start with phase_sel=3, win_len=8, threshold=4 -> sel_clr high for 2 cycles, then tap_en=0x008 for 16 cycles, then the first DECIDE at cycle 2+16+8.
REQ-038 fb_in=1 constantly with threshold=4, win_len=8 -> ctr_ud=0 and one ctr_en pulse every 10 cycles; lock stays 0.
REQ-039 fb_in alternating 1/0 with win_len=8, threshold=4 -> no ctr_en; lock rises on the 4th DECIDE and stays high.
REQ-040 Start with phase_sel=12 -> err high for exactly one cycle, busy stays 0, and tap_en stays 0.
REQ-041 stop asserted in the DECIDE cycle that would go to STEP -> no ctr_en pulse, IDLE next cycle, and lock=0.
REQ-042 reset pulsed mid-SAMPLE with win_len=0 on restart -> all outputs at reset values, and the restarted run uses a 1-cycle window.

Source files
------------

// File: rtl/feedback_seq_ctrl.sv
// Calibration sequencer for a gray-clock tap selector: clears the selector, settles,
// samples the fed-back bit over a window and steps an up/down counter until the loop is balanced.
module feedback_seq_ctrl #(
  parameter int SEL_N      = 10,
  parameter int WIN_W      = 8,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_N     = 4
) (
  input  logic             clk_ext,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       phase_sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic [WIN_W-1:0] threshold,
  input  logic             fb_in,
  output logic [SEL_N-1:0] tap_en,
  output logic             sel_clr,
  output logic             ctr_en,
  output logic             ctr_ud,
  output logic             busy,
  output logic             lock,
  output logic             err,
  output logic [2:0]       state
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam int BAL_W = $clog2(LOCK_N + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DECIDE = 3'd4,
    STEP   = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIN_W-1:0] ones_q;
  logic [BAL_W-1:0] bal_q;
  logic [3:0]       phase_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] thr_q;
  logic             arm_q;
  logic [SEL_N-1:0] tap_q;
  logic             sel_clr_q;
  logic             ctr_en_q;
  logic             ctr_ud_q;
  logic             busy_q;
  logic             lock_q;
  logic             err_q;

  logic [CNT_W-1:0] win_last_d;
  logic [BAL_W-1:0] bal_d;
  logic             phase_ok_d;

  assign win_last_d = CNT_W'(win_q - 1'b1);
  assign bal_d      = (bal_q == BAL_W'(LOCK_N)) ? bal_q : bal_q + 1'b1;
  assign phase_ok_d = (32'(phase_sel) < SEL_N);

  always_ff @(posedge clk_ext) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ones_q    <= '0;
      bal_q     <= '0;
      phase_q   <= '0;
      win_q     <= WIN_W'(1);
      thr_q     <= '0;
      arm_q     <= 1'b1;
      tap_q     <= '0;
      sel_clr_q <= 1'b0;
      ctr_en_q  <= 1'b0;
      ctr_ud_q  <= 1'b1;
      busy_q    <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q    <= 1'b0;
      ctr_en_q <= 1'b0;
      if (state_q != IDLE && stop) begin
        // Abort: start must be seen low again before the next run can begin.
        state_q   <= IDLE;
        cnt_q     <= '0;
        bal_q     <= '0;
        arm_q     <= 1'b0;
        tap_q     <= '0;
        sel_clr_q <= 1'b0;
        busy_q    <= 1'b0;
        lock_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!start) begin
              arm_q <= 1'b1;
            end else if (arm_q && !stop) begin
              arm_q <= 1'b0;
              if (phase_ok_d) begin
                phase_q   <= phase_sel;
                win_q     <= (win_len == '0) ? WIN_W'(1) : win_len;
                thr_q     <= threshold;
                cnt_q     <= '0;
                state_q   <= CLEAR;
                sel_clr_q <= 1'b1;
                busy_q    <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          CLEAR: begin
            if (cnt_q == CNT_W'(1)) begin
              cnt_q     <= '0;
              state_q   <= SETTLE;
              sel_clr_q <= 1'b0;
              tap_q     <= {{(SEL_N-1){1'b0}}, 1'b1} << phase_q;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
              cnt_q   <= '0;
              ones_q  <= '0;
              state_q <= SAMPLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          SAMPLE: begin
            ones_q <= ones_q + WIN_W'(fb_in);
            if (cnt_q == win_last_d) begin
              cnt_q   <= '0;
              state_q <= DECIDE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DECIDE: begin
            ones_q <= '0;
            if (ones_q > thr_q) begin
              ctr_ud_q <= 1'b0;
              ctr_en_q <= 1'b1;
              state_q  <= STEP;
            end else if (ones_q < thr_q) begin
              ctr_ud_q <= 1'b1;
              ctr_en_q <= 1'b1;
              state_q  <= STEP;
            end else begin
              bal_q   <= bal_d;
              lock_q  <= (bal_d == BAL_W'(LOCK_N));
              state_q <= SAMPLE;
            end
          end
          STEP: begin
            bal_q   <= '0;
            lock_q  <= 1'b0;
            ones_q  <= '0;
            cnt_q   <= '0;
            state_q <= SAMPLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tap_en  = tap_q;
  assign sel_clr = sel_clr_q;
  assign ctr_en  = ctr_en_q;
  assign ctr_ud  = ctr_ud_q;
  assign busy    = busy_q;
  assign lock    = lock_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule
